// File: rtl/cdc_handshake_rx.sv
// Receive side of a 4-phase req/ack CDC transfer: captures the source-held word,
// presents it on valid/ready, and returns an ack level. Optional watchdog: CDC_HSK_RX_TIMEOUT_EN.
module cdc_handshake_rx #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic              clock,
    input  logic              srst,
    input  logic              req_sync,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_VALID = 2'd1,
        ST_ACK   = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic              armed_q, armed_d;
    logic              ack_q, ack_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;

    generate
        if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
            $error("TIMEOUT_CYCLES must be at least 2");
        end
    endgenerate

    // Handshake state and registered outputs
    always_ff @(posedge clock) begin
        if (srst) begin
            state_q     <= ST_IDLE;
            armed_q     <= 1'b0;
            ack_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            armed_q     <= armed_d;
            ack_q       <= ack_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so that every port is driven straight from a flop.
    always_comb begin
        state_d     = state_q;
        armed_d     = armed_q;
        ack_d       = ack_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        case (state_q)
            ST_IDLE: begin
                ack_d       = 1'b0;
                out_valid_d = 1'b0;
                if (!req_sync) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    out_data_d  = data_in;
                    out_valid_d = 1'b1;
                    state_d     = ST_VALID;
                end else begin
                    armed_d = armed_q;
                end
            end
            ST_VALID: begin
                // A request dropping here is a source violation; the word is still delivered.
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ack_d       = 1'b1;
                    state_d     = ST_ACK;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            ST_ACK: begin
                if (!req_sync) begin
                    ack_d   = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    ack_d = 1'b1;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                armed_d     = 1'b0;
                ack_d       = 1'b0;
                out_valid_d = 1'b0;
                out_data_d  = '0;
            end
        endcase
    end

    assign ack       = ack_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

`ifdef CDC_HSK_RX_TIMEOUT_EN
    localparam int unsigned       CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // Watchdog counter and sticky error flag
    always_ff @(posedge clock) begin
        if (srst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Counter is held at zero outside ACK so it starts fresh on every entry, and saturates.
    always_comb begin
        cnt_d = '0;
        err_d = err_q;
        if (state_q == ST_ACK) begin
            if (cnt_q == CNT_MAX) begin
                cnt_d = cnt_q;
                if (req_sync) begin
                    err_d = 1'b1;
                end else begin
                    err_d = err_q;
                end
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = '0;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_handshake_rx.sv
// Directed self-checking bench for cdc_handshake_rx (watchdog expectations follow CDC_HSK_RX_TIMEOUT_EN).
module tb_cdc_handshake_rx;

    localparam int unsigned DW = 8;
`ifdef CDC_HSK_RX_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clock;
    logic          srst;
    logic          req_sync;
    logic [DW-1:0] data_in;
    logic          ack;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          err;

    int checks;
    int errors;

    cdc_handshake_rx #(.DATA_W(DW), .TIMEOUT_CYCLES(16)) dut (
        .clock    (clock),
        .srst     (srst),
        .req_sync (req_sync),
        .data_in  (data_in),
        .ack      (ack),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .err      (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        req_sync = 1'b1; srst = 1'b1; out_ready = 1'b0; data_in = 8'h00;
        tick(); tick();
        srst = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rst_ack got=%b exp=0", ack); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL rst_data got=%h exp=00", out_data); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%b exp=0", err); end
        for (int i = 0; i < 6; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL held_req_no_capture cyc=%0d got=%b exp=0", i, out_valid); end
        end
        req_sync = 1'b0; tick();
        req_sync = 1'b1; data_in = 8'hA5; tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got=%b exp=1", out_valid); end
        checks++; if (out_data !== 8'hA5) begin errors++; $display("FAIL first_data got=%h exp=a5", out_data); end
        out_ready = 1'b1; tick();
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL first_ack got=%b exp=1", ack); end
        req_sync = 1'b0; tick();
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL first_ack_low got=%b exp=0", ack); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] exp_words [3];
        exp_words[0] = 8'h01; exp_words[1] = 8'h02; exp_words[2] = 8'h03;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data_in = exp_words[i]; req_sync = 1'b1; tick();
            checks++; if (out_valid !== 1'b1 || ack !== 1'b0) begin errors++; $display("FAIL b2b_valid[%0d] got v=%b a=%b exp v=1 a=0", i, out_valid, ack); end
            checks++; if (out_data !== exp_words[i]) begin errors++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, out_data, exp_words[i]); end
            tick();
            checks++; if (out_valid !== 1'b0 || ack !== 1'b1) begin errors++; $display("FAIL b2b_ack[%0d] got v=%b a=%b exp v=0 a=1", i, out_valid, ack); end
            req_sync = 1'b0; tick();
            checks++; if (ack !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle[%0d] got v=%b a=%b exp v=0 a=0", i, out_valid, ack); end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; data_in = 8'h3C; req_sync = 1'b1; tick();
        data_in = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h3C || ack !== 1'b0) begin
                errors++; $display("FAIL bp_hold cyc=%0d got v=%b d=%h a=%b exp v=1 d=3c a=0", i, out_valid, out_data, ack);
            end
        end
        out_ready = 1'b1; tick();
        checks++; if (ack !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_accept got v=%b a=%b exp v=0 a=1", out_valid, ack); end
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_data !== 8'h3C || ack !== 1'b1) begin errors++; $display("FAIL ack_phase_data cyc=%0d got d=%h a=%b exp d=3c a=1", i, out_data, ack); end
        end
        req_sync = 1'b0; tick();
        checks++; if (ack !== 1'b0 || out_data !== 8'h3C) begin errors++; $display("FAIL bp_release got d=%h a=%b exp d=3c a=0", out_data, ack); end
        data_in = 8'h00;
    endtask

    task automatic test_reset_in_ack();
        out_ready = 1'b1; data_in = 8'h5A; req_sync = 1'b1; tick();
        tick();
        checks++; if (ack !== 1'b1) begin errors++; $display("FAIL rack_pre got=%b exp=1", ack); end
        srst = 1'b1; tick();
        srst = 1'b0;
        checks++; if (ack !== 1'b0 || out_valid !== 1'b0 || out_data !== 8'h00) begin
            errors++; $display("FAIL rack_reset got a=%b v=%b d=%h exp a=0 v=0 d=00", ack, out_valid, out_data);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rack_no_recapture cyc=%0d got=%b exp=0", i, out_valid); end
        end
        req_sync = 1'b0; tick();
        req_sync = 1'b1; data_in = 8'h66; tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h66) begin errors++; $display("FAIL rack_recapture got v=%b d=%h exp v=1 d=66", out_valid, out_data); end
        tick();
        req_sync = 1'b0; tick();
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL rack_done got=%b exp=0", ack); end
        out_ready = 1'b0;
    endtask

    task automatic test_protocol_violation();
        out_ready = 1'b0; data_in = 8'h77; req_sync = 1'b1; tick();
        req_sync = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 8'h77) begin errors++; $display("FAIL viol_hold cyc=%0d got v=%b d=%h exp v=1 d=77", i, out_valid, out_data); end
        end
        out_ready = 1'b1; tick();
        checks++; if (ack !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL viol_ack got a=%b v=%b exp a=1 v=0", ack, out_valid); end
        out_ready = 1'b0; tick();
        checks++; if (ack !== 1'b0) begin errors++; $display("FAIL viol_idle got=%b exp=0", ack); end
    endtask

    task automatic test_timeout();
        logic exp_err;
        out_ready = 1'b1; data_in = 8'h11; req_sync = 1'b1; tick();
        tick();
        out_ready = 1'b0;
        for (int cyc = 1; cyc <= 18; cyc++) begin
            exp_err = TO_EN && (cyc >= 17);
            checks++; if (err !== exp_err || ack !== 1'b1) begin
                errors++; $display("FAIL timeout ack_cycle=%0d got e=%b a=%b exp e=%b a=1", cyc, err, ack, exp_err);
            end
            tick();
        end
        req_sync = 1'b0; tick();
        exp_err = TO_EN;
        checks++; if (err !== exp_err || ack !== 1'b0) begin errors++; $display("FAIL timeout_sticky got e=%b a=%b exp e=%b a=0", err, ack, exp_err); end
        tick();
        checks++; if (err !== exp_err) begin errors++; $display("FAIL timeout_sticky2 got=%b exp=%b", err, exp_err); end
        srst = 1'b1; tick(); srst = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL timeout_clear got=%b exp=0", err); end
    endtask

    initial begin
        checks = 0; errors = 0;
        srst = 1'b1; req_sync = 1'b0; data_in = 8'h00; out_ready = 1'b0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_reset_in_ack();
        test_protocol_violation();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
